// File: rtl/cnt_chk_pkg.sv
// Shared types and default widths for the counter sequence checker.
// Optional build macro: CNT_CHK_HOLD_EN (repeated samples are stalls).
package cnt_chk_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKING  = 2'd1,
    LOCKED   = 2'd2
  } cnt_chk_state_e;

  localparam int unsigned DEF_CNT_W  = 3;
  localparam int unsigned DEF_LOCK_N = 2;
  localparam int unsigned DEF_ERR_W  = 8;
  localparam int unsigned DEF_WRAP_W = 8;

  function automatic int unsigned run_width(
    input int unsigned lock_n
  );
    return (lock_n < 1) ? 1 : $clog2(lock_n + 1);
  endfunction

endpackage

// File: rtl/cnt_onehot_dec.sv
// Binary to one-hot decoder with enable; output is all-zero when disabled.
// Pure combinational; the parent registers the result.
module cnt_onehot_dec #(
  parameter int unsigned W = 3
) (
  input  logic              en,
  input  logic [W-1:0]      sel,
  output logic [2**W-1:0]   dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/count_sequence_checker.sv
// Follows a free-running counter, tracks lock, errors and wraps.
// Build macro CNT_CHK_HOLD_EN: a repeated sample is a stall, not an error.
module count_sequence_checker
  import cnt_chk_pkg::*;
#(
  parameter int unsigned CNT_W  = DEF_CNT_W,
  parameter int unsigned LOCK_N = DEF_LOCK_N,
  parameter int unsigned ERR_W  = DEF_ERR_W,
  parameter int unsigned WRAP_W = DEF_WRAP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cnt_valid,
  input  logic [CNT_W-1:0]     cnt,
  input  logic                 clr_err,
  output logic                 locked,
  output logic                 err,
  output logic                 err_sticky,
  output logic [ERR_W-1:0]     err_cnt,
  output logic [WRAP_W-1:0]    wrap_cnt,
  output logic [2**CNT_W-1:0]  t_sig
);

  localparam int unsigned RUN_W = run_width(LOCK_N);
  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_N);

  cnt_chk_state_e      state, state_n;
  logic [CNT_W-1:0]    prev, prev_n;
  logic [RUN_W-1:0]    run, run_n;
  logic [RUN_W-1:0]    run_inc;
  logic [CNT_W-1:0]    prev_inc;
  logic                step_ok;
  logic                stall;
  logic                err_n;
  logic                wrap_inc;
  logic                dec_en;
  logic [2**CNT_W-1:0] dec;

  assign prev_inc = prev + CNT_W'(1);
  assign run_inc  = run + RUN_W'(1);
  assign step_ok  = (cnt == prev_inc);

`ifdef CNT_CHK_HOLD_EN
  assign stall = (cnt == prev);
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_n  = state;
    run_n    = run;
    prev_n   = prev;
    err_n    = 1'b0;
    wrap_inc = 1'b0;
    if (cnt_valid) begin
      prev_n = cnt;
      unique case (state)
        UNLOCKED: begin
          state_n = LOCKING;
          run_n   = '0;
        end
        LOCKING: begin
          if (stall) begin
            run_n = run;
          end else if (step_ok) begin
            run_n = run_inc;
            if (run_inc == RUN_LOCK) state_n = LOCKED;
          end else begin
            run_n = '0;
          end
        end
        LOCKED: begin
          if (stall) begin
            state_n = LOCKED;
          end else if (step_ok) begin
            wrap_inc = (cnt == '0);
          end else begin
            err_n   = 1'b1;
            state_n = LOCKING;
            run_n   = '0;
          end
        end
        default: begin
          state_n = UNLOCKED;
          run_n   = '0;
        end
      endcase
    end
  end

  assign dec_en = cnt_valid && (state_n == LOCKED);

  cnt_onehot_dec #(
    .W(CNT_W)
  ) u_dec (
    .en  (dec_en),
    .sel (cnt),
    .dec (dec)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= UNLOCKED;
      prev       <= '0;
      run        <= '0;
      locked     <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
      t_sig      <= '0;
    end else begin
      state  <= state_n;
      prev   <= prev_n;
      run    <= run_n;
      err    <= err_n;
      locked <= (state_n == LOCKED);
      if (cnt_valid) t_sig <= dec;
      if (wrap_inc && (wrap_cnt != '1))
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      // A fresh error outranks a same-cycle clear.
      if (err_n) begin
        err_sticky <= 1'b1;
        if (clr_err)
          err_cnt <= ERR_W'(1);
        else if (err_cnt != '1)
          err_cnt <= err_cnt + ERR_W'(1);
      end else if (clr_err) begin
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_count_sequence_checker.sv
// Randomized and directed bench for count_sequence_checker.
// Reference model tracks lock as a run length of consecutive increments.
module tb_count_sequence_checker;

  localparam int CNT_W  = 3;
  localparam int LOCK_N = 2;
  localparam int ERR_W  = 8;
  localparam int WRAP_W = 8;
  localparam int CMAX   = 2**CNT_W;
  localparam int ESAT   = 2**ERR_W - 1;
  localparam int WSAT   = 2**WRAP_W - 1;

`ifdef CNT_CHK_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                cnt_valid = 1'b0;
  logic [CNT_W-1:0]    cnt = '0;
  logic                clr_err = 1'b0;
  logic                locked;
  logic                err;
  logic                err_sticky;
  logic [ERR_W-1:0]    err_cnt;
  logic [WRAP_W-1:0]   wrap_cnt;
  logic [CMAX-1:0]     t_sig;

  int passed = 0;
  int total  = 0;

  bit              m_seen;
  int              m_run;
  logic [CNT_W-1:0] m_prev;
  bit              m_locked;
  bit              m_err;
  bit              m_sticky;
  int              m_errc;
  int              m_wrapc;
  logic [CMAX-1:0] m_tsig;

  always #5 clk = ~clk;

  count_sequence_checker #(
    .CNT_W  (CNT_W),
    .LOCK_N (LOCK_N),
    .ERR_W  (ERR_W),
    .WRAP_W (WRAP_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cnt_valid  (cnt_valid),
    .cnt        (cnt),
    .clr_err    (clr_err),
    .locked     (locked),
    .err        (err),
    .err_sticky (err_sticky),
    .err_cnt    (err_cnt),
    .wrap_cnt   (wrap_cnt),
    .t_sig      (t_sig)
  );

  task automatic model(input bit r, input bit v,
                       input logic [CNT_W-1:0] c, input bit clr);
    bit was_locked;
    bit ok;
    m_err = 1'b0;
    if (r) begin
      m_seen = 0; m_run = 0; m_prev = '0; m_locked = 0;
      m_sticky = 0; m_errc = 0; m_wrapc = 0; m_tsig = '0;
      return;
    end
    if (v) begin
      was_locked = m_locked;
      ok = (int'(c) == (int'(m_prev) + 1) % CMAX);
      if (!m_seen) begin
        m_seen = 1; m_run = 0;
      end else if (HOLD && c == m_prev) begin
        m_run = m_run;
      end else if (ok) begin
        m_run++;
        if (was_locked && c == '0 && m_wrapc < WSAT) m_wrapc++;
      end else begin
        m_err = was_locked;
        m_run = 0;
      end
      m_prev   = c;
      m_locked = m_seen && (m_run >= LOCK_N);
      m_tsig   = m_locked ? (CMAX'(1) << c) : '0;
    end
    if (m_err) begin
      m_sticky = 1;
      m_errc   = clr ? 1 : ((m_errc < ESAT) ? m_errc + 1 : m_errc);
    end else if (clr) begin
      m_sticky = 0; m_errc = 0;
    end
  endtask

  task automatic drive(input bit r, input bit v,
                       input logic [CNT_W-1:0] c, input bit clr);
    rst = r; cnt_valid = v; cnt = c; clr_err = clr;
    @(posedge clk);
    #1;
    model(r, v, c, clr);
  endtask

  task automatic test_reset();
    drive(1, 1, 3'd5, 0);
    drive(1, 1, 3'd5, 0);
    total++;
    if (locked !== 1'b0 || err !== 1'b0 || err_sticky !== 1'b0)
      $display("FAIL reset_flags: got l=%b e=%b s=%b need 0 0 0",
               locked, err, err_sticky);
    else passed++;
    total++;
    if (err_cnt !== '0 || wrap_cnt !== '0 || t_sig !== '0)
      $display("FAIL reset_cnts: got ec=%0d wc=%0d t=%h need 0 0 0",
               err_cnt, wrap_cnt, t_sig);
    else passed++;
  endtask

  task automatic test_lock();
    drive(0, 1, 3'd0, 0);
    drive(0, 1, 3'd1, 0);
    total++;
    if (locked !== m_locked)
      $display("FAIL lock_early: got %b need %b", locked, m_locked);
    else passed++;
    drive(0, 1, 3'd2, 0);
    total++;
    if (locked !== 1'b1)
      $display("FAIL lock_after2: got %b need 1", locked);
    else passed++;
    drive(0, 1, 3'd3, 0);
    total++;
    if (t_sig !== 8'h08)
      $display("FAIL tsig_3: got %h need 08", t_sig);
    else passed++;
  endtask

  task automatic test_wrap_and_err();
    for (int i = 4; i < 10; i++) drive(0, 1, CNT_W'(i % CMAX), 0);
    total++;
    if (wrap_cnt !== WRAP_W'(m_wrapc) || wrap_cnt !== 8'd1)
      $display("FAIL wrap_one: got %0d need 1", wrap_cnt);
    else passed++;
    drive(0, 1, 3'd2, 0);
    drive(0, 1, 3'd5, 0);
    total++;
    if (err !== 1'b1 || err_sticky !== 1'b1 || err_cnt !== 8'd1)
      $display("FAIL jump_err: got e=%b s=%b c=%0d need 1 1 1",
               err, err_sticky, err_cnt);
    else passed++;
    total++;
    if (locked !== 1'b0 || t_sig !== '0)
      $display("FAIL jump_unlock: got l=%b t=%h need 0 00", locked, t_sig);
    else passed++;
    drive(0, 1, 3'd6, 0);
    total++;
    if (err !== 1'b0 || locked !== m_locked)
      $display("FAIL err_pulse: got e=%b l=%b need 0 %b", err, locked, m_locked);
    else passed++;
    drive(0, 1, 3'd7, 0);
    total++;
    if (locked !== 1'b1 || t_sig !== 8'h80)
      $display("FAIL relock: got l=%b t=%h need 1 80", locked, t_sig);
    else passed++;
  endtask

  task automatic test_valid_low();
    logic [CMAX-1:0] t0;
    t0 = m_tsig;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 3'd0, 0);
      total++;
      if (locked !== 1'b1 || err !== 1'b0 || t_sig !== t0)
        $display("FAIL valid_low_%0d: got l=%b e=%b t=%h need 1 0 %h",
                 i, locked, err, t_sig, t0);
      else passed++;
    end
    drive(0, 1, m_prev + 3'd1, 0);
    total++;
    if (locked !== 1'b1 || err !== 1'b0 || wrap_cnt !== WRAP_W'(m_wrapc))
      $display("FAIL resume: got l=%b e=%b w=%0d need 1 0 %0d",
               locked, err, wrap_cnt, m_wrapc);
    else passed++;
  endtask

  task automatic test_clr_err();
    drive(0, 1, m_prev + 3'd3, 1);
    total++;
    if (err !== 1'b1 || err_sticky !== 1'b1 || err_cnt !== 8'd1)
      $display("FAIL clr_vs_err: got e=%b s=%b c=%0d need 1 1 1",
               err, err_sticky, err_cnt);
    else passed++;
    drive(0, 1, m_prev + 3'd1, 0);
    drive(0, 1, m_prev + 3'd1, 0);
    drive(0, 0, 3'd0, 1);
    total++;
    if (err_sticky !== 1'b0 || err_cnt !== '0 || locked !== 1'b1)
      $display("FAIL clr_alone: got s=%b c=%0d l=%b need 0 0 1",
               err_sticky, err_cnt, locked);
    else passed++;
  endtask

  task automatic test_stall();
    while (m_prev != 3'd2) drive(0, 1, m_prev + 3'd1, 0);
    drive(0, 1, 3'd3, 0);
    drive(0, 1, 3'd3, 0);
    total++;
    if (err !== m_err || locked !== m_locked || err_cnt !== ERR_W'(m_errc))
      $display("FAIL repeat_3: got e=%b l=%b c=%0d need %b %b %0d",
               err, locked, err_cnt, m_err, m_locked, m_errc);
    else passed++;
    drive(0, 1, 3'd4, 0);
    total++;
    if (locked !== m_locked || err !== 1'b0 || t_sig !== m_tsig)
      $display("FAIL after_4: got l=%b e=%b t=%h need %b 0 %h",
               locked, err, t_sig, m_locked, m_tsig);
    else passed++;
  endtask

  task automatic test_rst_mid();
    for (int i = 0; i < 4; i++) drive(0, 1, m_prev + 3'd1, 0);
    drive(1, 1, m_prev + 3'd4, 1);
    total++;
    if (locked !== 1'b0 || err !== 1'b0 || err_sticky !== 1'b0 ||
        err_cnt !== '0 || wrap_cnt !== '0 || t_sig !== '0)
      $display("FAIL rst_mid: got l=%b e=%b s=%b c=%0d w=%0d t=%h need all 0",
               locked, err, err_sticky, err_cnt, wrap_cnt, t_sig);
    else passed++;
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] c;
    bit v, r, clr;
    int sel;
    c = m_prev;
    for (int i = 0; i < 3000; i++) begin
      r   = ($urandom_range(0, 249) == 0);
      v   = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 39) == 0);
      sel = $urandom_range(0, 15);
      if (v) begin
        if (sel == 0)      c = CNT_W'($urandom);
        else if (sel == 1) c = c;
        else               c = c + 3'd1;
      end
      drive(r, v, v ? c : CNT_W'($urandom), clr);
      if (r) c = '0;
      total++;
      if (locked !== m_locked || err !== m_err || err_sticky !== m_sticky ||
          err_cnt !== ERR_W'(m_errc) || wrap_cnt !== WRAP_W'(m_wrapc) ||
          t_sig !== m_tsig)
        $display("FAIL rand_%0d: got l=%b e=%b s=%b c=%0d w=%0d t=%h need %b %b %b %0d %0d %h",
                 i, locked, err, err_sticky, err_cnt, wrap_cnt, t_sig,
                 m_locked, m_err, m_sticky, m_errc, m_wrapc, m_tsig);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap_and_err();
    test_valid_low();
    test_clr_err();
    test_stall();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
